instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: DEPTH_WORDS, 32, number of 32-bit words in the target instruction memory.
REQ-002 Parameter: BASE_ADDR, 32'h0, byte address of word 0.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; the clock and reset ports are named clk_i and rst_i.
REQ-004 Port: clk_i  input  1  rising-edge clock.
REQ-005 Port: rst_i  input  1  synchronous active-high reset.
REQ-006 Port: start_i  input  1  begin a load; sampled in IDLE or DONE.
REQ-007 Port: finish_i  input  1  end a load early; sampled in FILL.
REQ-008 Port: byte_valid_i  input  1  byte_data_i holds a valid byte.
REQ-009 Port: byte_data_i  input  8  program byte stream, most significant byte of each word first.
REQ-010 Port: byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-011 Port: wr_en_o  output  1  one-cycle write strobe to the instruction memory write port.
REQ-012 Port: wr_addr_o  output  32  byte address of the word being written (word-aligned).
REQ-013 Port: wr_data_o  output  32  instruction word being written.
REQ-014 Port: word_cnt_o  output  6  number of words written in the current load.
REQ-015 Port: done_o  output  1  load complete.
REQ-016 Port: cpu_hold_o  output  1  holds the CPU (PC and pipeline) while the program is incomplete.

Function
REQ-017 The FSM SHALL have three states: IDLE, FILL and DONE.
REQ-018 Transitions: IDLE --start_i--> FILL; FILL --last word or finish_i--> DONE; DONE --start_i--> FILL. start_i SHALL be ignored in FILL.
REQ-019 Entering FILL SHALL clear the byte counter (0..3), word_cnt_o and the assembly register.
REQ-020 byte_ready_o SHALL be 1 only in FILL, combinationally from state.
REQ-021 A byte is accepted when byte_valid_i && byte_ready_o; accepted byte k (k=0..3) SHALL land in bits [31-8k:24-8k].
REQ-022 On acceptance of byte 3 in cycle t, in cycle t+1: wr_en_o=1 for exactly one cycle; wr_addr_o=BASE_ADDR+4*word_cnt (pre-increment); wr_data_o=assembled word. word_cnt_o increments at the same edge.
REQ-023 Bytes arriving in the write cycle SHALL be accepted with no stall; sustained one byte per cycle yields one write every 4 cycles.
REQ-024 When the accepted word is word DEPTH_WORDS-1, the FSM SHALL enter DONE at the same edge that raises the final wr_en_o.
REQ-025 finish_i in FILL with a byte accepted in the same cycle: count the byte first, then evaluate finish_i.
REQ-026 finish_i with 1..3 bytes pending SHALL flush one word with the missing low bytes zero, written in the next cycle, entering DONE at the same edge.
REQ-027 finish_i with 0 bytes pending SHALL enter DONE with no write.
REQ-028 done_o = (state==DONE); cpu_hold_o = (state!=DONE).
REQ-029 wr_addr_o and wr_data_o SHALL hold their last written values when wr_en_o=0.
REQ-030 Bytes presented in IDLE or DONE SHALL be dropped and SHALL not affect any counter.

Reset
REQ-031 rst_i=1 at a rising edge SHALL force IDLE with byte_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, word_cnt_o=0, done_o=0, cpu_hold_o=1.
REQ-032 Reset during FILL SHALL discard partial bytes and issue no write, including a write scheduled for the following cycle.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2), BYTES_PER_WORD=4 and the default DEPTH_WORDS.
REQ-034 The byte-to-word assembly (byte counter, shift register, zero-padding) SHALL be a sub-module named word_packer; the FSM, address counter and write strobe stay in instr_mem_loader.

Verification
REQ-035 Reset, then start_i, then bytes 8C,01,00,04 on consecutive cycles -> one cycle later wr_en_o=1, wr_addr_o=0, wr_data_o=32'h8C010004, word_cnt_o=1.
REQ-036 Stream 128 bytes without gaps -> 32 writes at addresses 0,4,...,124 every 4 cycles; done_o=1 and cpu_hold_o=0 with the last strobe; byte_ready_o=0 afterwards.
REQ-037 Six bytes 11..16, then finish_i together with no byte -> writes 32'h11121314 @0 and 32'h15160000 @4; done_o=1; word_cnt_o=2.
REQ-038 Two bytes accepted, then rst_i=1 one cycle after the third byte is accepted -> no write occurs; all outputs at reset values; cpu_hold_o=1.
REQ-039 byte_valid_i toggled randomly with 8 bytes offered in IDLE, then start_i -> IDLE bytes dropped; only bytes accepted in FILL appear in writes.
REQ-040 After DONE, a second start_i -> word_cnt_o=0, the next write goes to BASE_ADDR, and done_o drops on the cycle after start_i.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: state encoding,
// word geometry and the byte-insertion helper used by the word packer.
package instr_mem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int BYTES_PER_WORD      = 4;
   localparam int DEFAULT_DEPTH_WORDS = 32;

   // Places a byte into a word, byte 0 being the most significant lane.
   function automatic logic [31:0] insert_byte(input logic [31:0] word_in,
                                               input logic [7:0]  byte_in,
                                               input logic [1:0]  idx);
      logic [31:0] res;
      res = word_in;
      case (idx)
         2'd0:    res[31:24] = byte_in;
         2'd1:    res[23:16] = byte_in;
         2'd2:    res[15:8]  = byte_in;
         2'd3:    res[7:0]   = byte_in;
         default: res        = word_in;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// Assembles the big-endian byte stream into 32-bit words. The assembly
// register starts at zero, so a flushed partial word is zero padded in the
// low lanes without extra logic.
module word_packer
   import instr_mem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic        flush_i,
   input  logic [7:0]  byte_i,
   output logic        word_full_o,
   output logic        pending_o,
   output logic [31:0] word_o
);

   localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] merged_s;

   // Merge the incoming byte and compute the next assembly state.
   always_comb begin
      merged_s    = insert_byte(asm_q, byte_i, cnt_q);
      word_full_o = accept_i && (cnt_q == LAST_BYTE_IDX);
      pending_o   = accept_i || (cnt_q != 2'd0);
      if (accept_i) begin
         word_o = merged_s;
      end else begin
         word_o = asm_q;
      end
      if (clear_i || flush_i || word_full_o) begin
         cnt_d = 2'd0;
         asm_d = 32'd0;
      end else if (accept_i) begin
         cnt_d = cnt_q + 2'd1;
         asm_d = merged_s;
      end else begin
         cnt_d = cnt_q;
         asm_d = asm_q;
      end
   end

   // Byte counter and assembly register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= 2'd0;
         asm_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
         asm_q <= asm_d;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program byte stream into the instruction memory one word at a
// time and holds the CPU until the load has completed.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        finish_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        wr_en_o,
   output logic [31:0] wr_addr_o,
   output logic [31:0] wr_data_o,
   output logic [5:0]  word_cnt_o,
   output logic        done_o,
   output logic        cpu_hold_o
);

   localparam logic [5:0] LAST_WORD = 6'(DEPTH_WORDS - 1);

   state_e      state_q, state_d;
   logic [5:0]  word_cnt_q, word_cnt_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        accept_s, clear_s, flush_s;
   logic        word_full_s, pending_s;
   logic [31:0] word_s;

   // Handshake and packer control decoded from the current state.
   always_comb begin
      byte_ready_o = (state_q == ST_FILL);
      accept_s     = byte_valid_i && byte_ready_o;
      clear_s      = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      flush_s      = finish_i && (state_q == ST_FILL);
   end

   word_packer u_packer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_s),
      .accept_i    (accept_s),
      .flush_i     (flush_s),
      .byte_i      (byte_data_i),
      .word_full_o (word_full_s),
      .pending_o   (pending_s),
      .word_o      (word_s)
   );

   // Next-state logic, address counter and write strobe generation.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d    = ST_FILL;
               word_cnt_d = 6'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_FILL: begin
            // A completed word and a flush of pending bytes share one write.
            if (word_full_s || (flush_s && pending_s)) begin
               wr_en_d    = 1'b1;
               wr_addr_d  = BASE_ADDR + {24'd0, word_cnt_q, 2'b00};
               wr_data_d  = word_s;
               word_cnt_d = word_cnt_q + 6'd1;
            end else begin
               wr_en_d = 1'b0;
            end
            if (flush_s || (word_full_s && (word_cnt_q == LAST_WORD))) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FILL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset also cancels a pending write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         word_cnt_q <= 6'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= 32'd0;
         wr_data_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign wr_en_o    = wr_en_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign word_cnt_o = word_cnt_q;
   assign done_o     = (state_q == ST_DONE);
   assign cpu_hold_o = (state_q != ST_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a small reference model pushes
// expected memory writes into a scoreboard queue, and a monitor pops and
// compares them whenever the loader strobes a write.
module tb_instr_mem_loader;

   localparam logic [31:0] BASE = 32'h0;
   localparam int          DEPTH = 32;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        finish_i = 1'b0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_data_i = 8'h00;
   logic        byte_ready_o;
   logic        wr_en_o;
   logic [31:0] wr_addr_o;
   logic [31:0] wr_data_o;
   logic [5:0]  word_cnt_o;
   logic        done_o;
   logic        cpu_hold_o;

   instr_mem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .finish_i     (finish_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .wr_en_o      (wr_en_o),
      .wr_addr_o    (wr_addr_o),
      .wr_data_o    (wr_data_o),
      .word_cnt_o   (word_cnt_o),
      .done_o       (done_o),
      .cpu_hold_o   (cpu_hold_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb_q[$];
   int  n_cmp = 0;
   int  n_mis = 0;
   int  n_wr  = 0;

   // reference model state
   bit          m_fill  = 1'b0;
   int          m_nb    = 0;
   logic [31:0] m_acc   = 32'd0;
   int          m_words = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // scoreboard monitor: every write strobe must match the oldest expectation
   always @(negedge clk_i) begin
      if (wr_en_o === 1'b1) begin
         n_wr++;
         if (sb_q.size() == 0) begin
            chk("unexpected_wr", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            chk("wr_addr", wr_addr_o, e.addr);
            chk("wr_data", wr_data_o, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_word();
      wr_t e;
      e.addr = BASE + 32'(4 * m_words);
      e.data = m_acc;
      sb_q.push_back(e);
      m_words++;
      m_nb  = 0;
      m_acc = 32'd0;
   endtask

   // one cycle of stimulus; the model counts the byte first, then finish
   task automatic drive(input logic [7:0] b, input bit v, input bit fin);
      byte_valid_i = v;
      byte_data_i  = b;
      finish_i     = fin;
      tick();
      byte_valid_i = 1'b0;
      finish_i     = 1'b0;
      if (v && m_fill) begin
         m_acc = m_acc | ({24'd0, b} << (24 - 8 * m_nb));
         m_nb++;
         if (m_nb == 4) begin
            push_word();
            if (m_words == DEPTH) m_fill = 1'b0;
         end
      end
      if (fin && m_fill) begin
         if (m_nb > 0) push_word();
         m_fill = 1'b0;
      end
   endtask

   task automatic start_load();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      if (!m_fill) begin
         m_fill  = 1'b1;
         m_nb    = 0;
         m_acc   = 32'd0;
         m_words = 0;
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      byte_valid_i = 1'b0;
      start_i = 1'b0;
      finish_i = 1'b0;
      tick();
      tick();
      rst_i   = 1'b0;
      m_fill  = 1'b0;
      m_nb    = 0;
      m_acc   = 32'd0;
      m_words = 0;
   endtask

   task automatic check_reset_vals(input string pfx);
      @(negedge clk_i);
      chk({pfx, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
      chk({pfx, "_wr_en"}, {31'd0, wr_en_o}, 32'd0);
      chk({pfx, "_addr"}, wr_addr_o, 32'd0);
      chk({pfx, "_data"}, wr_data_o, 32'd0);
      chk({pfx, "_cnt"}, {26'd0, word_cnt_o}, 32'd0);
      chk({pfx, "_done"}, {31'd0, done_o}, 32'd0);
      chk({pfx, "_hold"}, {31'd0, cpu_hold_o}, 32'd1);
   endtask

   task automatic drain(input string tag);
      drive(8'h00, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      chk(tag, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      int wr0;
      int offered;
      do_reset();
      check_reset_vals("rst");

      // single word, back-to-back bytes
      start_load();
      drive(8'h8C, 1'b1, 1'b0);
      drive(8'h01, 1'b1, 1'b0);
      drive(8'h00, 1'b1, 1'b0);
      drive(8'h04, 1'b1, 1'b0);
      @(negedge clk_i);
      chk("w1_wr_en", {31'd0, wr_en_o}, 32'd1);
      chk("w1_cnt", {26'd0, word_cnt_o}, 32'd1);
      drain("w1_drain");

      // full image of DEPTH words, one byte per cycle
      do_reset();
      start_load();
      wr0 = n_wr;
      for (int i = 0; i < 4 * DEPTH; i++) begin
         drive(8'(i * 7 + 3), 1'b1, 1'b0);
      end
      @(negedge clk_i);
      chk("full_last_wr", {31'd0, wr_en_o}, 32'd1);
      chk("full_done", {31'd0, done_o}, 32'd1);
      chk("full_hold", {31'd0, cpu_hold_o}, 32'd0);
      chk("full_cnt", {26'd0, word_cnt_o}, 32'd32);
      drive(8'hAA, 1'b1, 1'b0);
      chk("full_ready_off", {31'd0, byte_ready_o}, 32'd0);
      chk("full_nwr", 32'(n_wr - wr0), 32'd32);
      drain("full_drain");

      // restart from DONE; start during FILL is ignored; empty finish
      start_load();
      @(negedge clk_i);
      chk("re_done_drop", {31'd0, done_o}, 32'd0);
      chk("re_cnt_clr", {26'd0, word_cnt_o}, 32'd0);
      drive(8'hDE, 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      drive(8'hAD, 1'b1, 1'b0);
      start_i = 1'b1;
      drive(8'hBE, 1'b1, 1'b0);
      start_i = 1'b0;
      drive(8'hEF, 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b1);
      @(negedge clk_i);
      chk("re_done", {31'd0, done_o}, 32'd1);
      chk("re_cnt", {26'd0, word_cnt_o}, 32'd1);
      drain("re_drain");

      // six bytes then an early finish with a partial word pending
      start_load();
      for (int i = 0; i < 6; i++) drive(8'h11 + 8'(i), 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b1);
      @(negedge clk_i);
      chk("fin_done", {31'd0, done_o}, 32'd1);
      chk("fin_cnt", {26'd0, word_cnt_o}, 32'd2);
      drain("fin_drain");

      // byte and finish in the same cycle: the byte joins the flushed word
      start_load();
      drive(8'hA1, 1'b1, 1'b0);
      drive(8'hA2, 1'b1, 1'b0);
      drive(8'hA3, 1'b1, 1'b1);
      @(negedge clk_i);
      chk("same_done", {31'd0, done_o}, 32'd1);
      drain("same_drain");

      // reset during FILL discards partial bytes
      do_reset();
      start_load();
      drive(8'h21, 1'b1, 1'b0);
      drive(8'h22, 1'b1, 1'b0);
      drive(8'h23, 1'b1, 1'b0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      m_fill = 1'b0;
      check_reset_vals("midrst");

      // reset on the edge that completes a word cancels the write
      start_load();
      drive(8'h31, 1'b1, 1'b0);
      drive(8'h32, 1'b1, 1'b0);
      drive(8'h33, 1'b1, 1'b0);
      rst_i = 1'b1;
      byte_valid_i = 1'b1;
      byte_data_i = 8'h34;
      tick();
      byte_valid_i = 1'b0;
      rst_i = 1'b0;
      m_fill = 1'b0;
      check_reset_vals("wrrst");
      drain("rst_drain");

      // bytes offered in IDLE are dropped; random gaps in FILL
      offered = 0;
      while (offered < 8) begin
         if ($urandom_range(1, 0) == 1) begin
            drive(8'($urandom), 1'b1, 1'b0);
            offered++;
         end else begin
            drive(8'h00, 1'b0, 1'b0);
         end
         chk("idle_ready", {31'd0, byte_ready_o}, 32'd0);
      end
      chk("idle_cnt", {26'd0, word_cnt_o}, 32'd0);
      start_load();
      offered = 0;
      while (offered < 8) begin
         if ($urandom_range(1, 0) == 1) begin
            drive(8'($urandom), 1'b1, 1'b0);
            offered++;
         end else begin
            drive(8'h00, 1'b0, 1'b0);
         end
      end
      drive(8'h00, 1'b0, 1'b1);
      @(negedge clk_i);
      chk("rnd_cnt", {26'd0, word_cnt_o}, 32'd2);
      chk("rnd_done", {31'd0, done_o}, 32'd1);
      drain("rnd_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
